ex_stage_vector_alu: RTL and testbench



---
 rtl/ex_stage_vector_alu.sv | 211 +++++++++++++++++++++
 tb/tb_ex_stage_vector_alu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_vector_alu.sv
// ex_stage_vector_alu
// 128-bit SIMD execute stage that feeds the EX/MEM pipeline register.
// Lane-wise ADD/SUB/AND/OR/XOR/RELU (and illegal ops) finish on the accept
// edge. MUL and DOT8 are iterative:
//   - the first slice of work is done on the accept edge itself;
//   - the remaining slices run while the block sits in BUSY.
// While BUSY, the decode stage is stalled through in_ready and the pipeline
// sees bubbles (regwrite_out=0).

module ex_stage_vector_alu #(
   parameter int LANE_W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   op,
   input  logic [127:0] src_a,
   input  logic [127:0] src_b,
   input  logic [4:0]   rd_in,
   input  logic         regwrite_in,
   output logic [127:0] alu_result_out,
   output logic [4:0]   rd_out,
   output logic         regwrite_out,
   output logic         out_valid,
   output logic         busy,
   output logic         illegal_op
);

   localparam int NUM_LANES = 128 / LANE_W;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_MUL  = 4'd5;
   localparam logic [3:0] OP_DOT8 = 4'd6;
   localparam logic [3:0] OP_RELU = 4'd7;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // The accept edge performs one step, so BUSY lasts one cycle less than the latency.
   localparam logic [4:0] MUL_BUSY_CYCLES = 5'(NUM_LANES - 1);
   localparam logic [4:0] DOT_BUSY_CYCLES = 5'd3;

   logic [0:0]            state;
   logic [4:0]            cnt;
   logic                  op_mul;
   logic [127:0]          a_sh;
   logic [127:0]          b_sh;
   logic [127-LANE_W:0]   mul_acc;
   logic [31:0]           dot_acc;
   logic [4:0]            rd_q;
   logic                  rw_q;

   logic                  accept;
   logic                  op_illegal;
   logic                  op_multi;

   logic                  is_mul;
   logic [127:0]          cur_a;
   logic [127:0]          cur_b;
   logic [127-LANE_W:0]   mul_base;
   logic [31:0]           dot_base;

   logic [LANE_W-1:0]     a_lane;
   logic [LANE_W-1:0]     b_lane;
   logic [LANE_W-1:0]     lane_prod;
   logic [127:0]          mul_next;
   logic [127:0]          a_next;
   logic [127:0]          b_next;

   logic signed [15:0]    dot_prod [4];
   logic signed [17:0]    dot_sum;
   logic [31:0]           dot_next;

   logic [LANE_W-1:0]     la;
   logic [LANE_W-1:0]     lb;
   logic [LANE_W-1:0]     lr;
   logic [127:0]          single_res;

   assign in_ready   = (state == ST_IDLE) && !flush && !reset;
   assign busy       = (state == ST_BUSY);
   assign accept     = in_valid && in_ready;
   assign op_illegal = op[3];
   assign op_multi   = (op == OP_MUL) || (op == OP_DOT8);

   // Iterative datapath takes live operands on the accept edge and the shifted copies while BUSY.
   always_comb begin
      if (state == ST_IDLE) begin
         cur_a    = src_a;
         cur_b    = src_b;
         is_mul   = (op == OP_MUL);
         mul_base = '0;
         dot_base = '0;
      end else begin
         cur_a    = a_sh;
         cur_b    = b_sh;
         is_mul   = op_mul;
         mul_base = mul_acc;
         dot_base = dot_acc;
      end
   end

   // The single shared multiplier always works on the lowest remaining lane.
   assign a_lane    = cur_a[LANE_W-1:0];
   assign b_lane    = cur_b[LANE_W-1:0];
   assign lane_prod = a_lane * b_lane;

   // Products enter at the top and drift down so lane 0 lands at the bottom after the last step.
   assign mul_next = {lane_prod, mul_base};
   assign a_next   = is_mul ? (cur_a >> LANE_W) : (cur_a >> 32);
   assign b_next   = is_mul ? (cur_b >> LANE_W) : (cur_b >> 32);

   // Four signed int8 products per step, summed and added to the running dot-product total.
   always_comb begin
      dot_sum = '0;
      for (int k = 0; k < 4; k++) begin
         dot_prod[k] = $signed(cur_a[8*k +: 8]) * $signed(cur_b[8*k +: 8]);
         dot_sum     = dot_sum + {{2{dot_prod[k][15]}}, dot_prod[k]};
      end
      dot_next = dot_base + {{14{dot_sum[17]}}, dot_sum};
   end

   // Single-cycle lane-wise ops; each lane wraps on its own, and illegal opcodes yield zero.
   always_comb begin
      single_res = '0;
      la         = '0;
      lb         = '0;
      lr         = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         la = src_a[i*LANE_W +: LANE_W];
         lb = src_b[i*LANE_W +: LANE_W];
         case (op)
            OP_ADD:  lr = la + lb;
            OP_SUB:  lr = la - lb;
            OP_AND:  lr = la & lb;
            OP_OR:   lr = la | lb;
            OP_XOR:  lr = la ^ lb;
            OP_RELU: lr = la[LANE_W-1] ? '0 : la;
            default: lr = '0;
         endcase
         single_res[i*LANE_W +: LANE_W] = lr;
      end
   end

   // Control state, iterative accumulators and the registered EX/MEM outputs; flush beats everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         op_mul         <= 1'b0;
         a_sh           <= '0;
         b_sh           <= '0;
         mul_acc        <= '0;
         dot_acc        <= '0;
         rd_q           <= '0;
         rw_q           <= 1'b0;
         alu_result_out <= '0;
         rd_out         <= '0;
         regwrite_out   <= 1'b0;
         out_valid      <= 1'b0;
         illegal_op     <= 1'b0;
      end else begin
         out_valid    <= 1'b0;
         regwrite_out <= 1'b0;
         illegal_op   <= 1'b0;
         if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
         end else if (state == ST_IDLE) begin
            if (accept) begin
               if (op_multi) begin
                  state   <= ST_BUSY;
                  cnt     <= (op == OP_MUL) ? MUL_BUSY_CYCLES : DOT_BUSY_CYCLES;
                  op_mul  <= (op == OP_MUL);
                  a_sh    <= a_next;
                  b_sh    <= b_next;
                  mul_acc <= mul_next[127:LANE_W];
                  dot_acc <= dot_next;
                  rd_q    <= rd_in;
                  rw_q    <= regwrite_in;
               end else begin
                  out_valid      <= 1'b1;
                  alu_result_out <= single_res;
                  rd_out         <= rd_in;
                  regwrite_out   <= regwrite_in && (rd_in != 5'd0) && !op_illegal;
                  illegal_op     <= op_illegal;
               end
            end
         end else begin
            cnt     <= cnt - 5'd1;
            a_sh    <= a_next;
            b_sh    <= b_next;
            mul_acc <= mul_next[127:LANE_W];
            dot_acc <= dot_next;
            if (cnt == 5'd1) begin
               state          <= ST_IDLE;
               out_valid      <= 1'b1;
               alu_result_out <= op_mul ? mul_next : {96'b0, dot_next};
               rd_out         <= rd_q;
               regwrite_out   <= rw_q && (rd_q != 5'd0);
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_stage_vector_alu.sv
// tb_ex_stage_vector_alu
// Directed vectors with hand-computed expectations.
// One instance uses 32-bit lanes and a second instance uses 8-bit lanes.
// Inputs change 1 time unit after a rising edge, and outputs are sampled
// at that same point.

module tb_ex_stage_vector_alu;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_MUL  = 4'd5;
   localparam logic [3:0] OP_DOT8 = 4'd6;
   localparam logic [3:0] OP_RELU = 4'd7;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_valid8;
   logic [3:0]   op;
   logic [127:0] src_a;
   logic [127:0] src_b;
   logic [4:0]   rd_in;
   logic         regwrite_in;

   logic         in_ready,       in_ready8;
   logic [127:0] alu_result_out, alu_result_out8;
   logic [4:0]   rd_out,         rd_out8;
   logic         regwrite_out,   regwrite_out8;
   logic         out_valid,      out_valid8;
   logic         busy,           busy8;
   logic         illegal_op,     illegal_op8;

   int total = 0;
   int bad   = 0;
   int lat;
   int seen;

   ex_stage_vector_alu #(.LANE_W(32)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .regwrite_in(regwrite_in),
      .alu_result_out(alu_result_out), .rd_out(rd_out), .regwrite_out(regwrite_out),
      .out_valid(out_valid), .busy(busy), .illegal_op(illegal_op)
   );

   ex_stage_vector_alu #(.LANE_W(8)) dut8 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
      .op(op), .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .regwrite_in(regwrite_in),
      .alu_result_out(alu_result_out8), .rd_out(rd_out8), .regwrite_out(regwrite_out8),
      .out_valid(out_valid8), .busy(busy8), .illegal_op(illegal_op8)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present one op for a single edge; returns 1 unit after the accept edge.
   task automatic applyStimulus(input bit narrow, input logic [3:0] o, input logic [127:0] a,
                                input logic [127:0] b, input logic [4:0] rd, input logic rw);
      op          = o;
      src_a       = a;
      src_b       = b;
      rd_in       = rd;
      regwrite_in = rw;
      if (narrow) in_valid8 = 1'b1;
      else        in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_valid8 = 1'b0;
   endtask

   // Count edges from the accept edge (1) until out_valid is seen, bounded by limit.
   task automatic waitOutput(input bit narrow, input int limit, output int l);
      l = 1;
      while (!(narrow ? out_valid8 : out_valid) && l < limit) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   // Issue a single-cycle op and check its result on the accept edge.
   task automatic runSingle(input bit narrow, input logic [3:0] o, input logic [127:0] a,
                            input logic [127:0] b, input logic [4:0] rd, input logic rw,
                            input logic [127:0] exp_res, input logic exp_rw, input string tag);
      applyStimulus(narrow, o, a, b, rd, rw);
      checkOutput({tag, "_valid"}, 128'(narrow ? out_valid8 : out_valid), 128'(1'b1));
      checkOutput({tag, "_result"}, narrow ? alu_result_out8 : alu_result_out, exp_res);
      checkOutput({tag, "_regwrite"}, 128'(narrow ? regwrite_out8 : regwrite_out), 128'(exp_rw));
      checkOutput({tag, "_rd"}, 128'(narrow ? rd_out8 : rd_out), 128'(rd));
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0;
      op = '0; src_a = '0; src_b = '0; rd_in = '0; regwrite_in = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_valid",    128'(out_valid),    128'(1'b0));
      checkOutput("rst_result",   alu_result_out,     128'h0);
      checkOutput("rst_rd",       128'(rd_out),       128'h0);
      checkOutput("rst_regwrite", 128'(regwrite_out), 128'(1'b0));
      checkOutput("rst_busy",     128'(busy),         128'(1'b0));
      checkOutput("rst_illegal",  128'(illegal_op),   128'(1'b0));
      checkOutput("rst_in_ready", 128'(in_ready),     128'(1'b0));
      reset = 1'b0;
      #1;
      checkOutput("idle_in_ready", 128'(in_ready), 128'(1'b1));
      @(posedge clk); #1;

      // Single-cycle lane ops, 32-bit lanes
      runSingle(0, OP_ADD, {4{32'hFFFFFFFF}}, {4{32'h1}}, 5'd5, 1'b1, 128'h0, 1'b1, "add_wrap");
      checkOutput("add_in_ready", 128'(in_ready), 128'(1'b1));
      runSingle(0, OP_SUB, 128'h0000000A_00000014_0000001E_00000000,
                128'h00000003_00000005_00000028_00000001, 5'd6, 1'b1,
                128'h00000007_0000000F_FFFFFFF6_FFFFFFFF, 1'b1, "sub");
      @(posedge clk); #1;
      checkOutput("hold_valid",    128'(out_valid),    128'(1'b0));
      checkOutput("hold_regwrite", 128'(regwrite_out), 128'(1'b0));
      checkOutput("hold_result",   alu_result_out,     128'h00000007_0000000F_FFFFFFF6_FFFFFFFF);
      checkOutput("hold_rd",       128'(rd_out),       128'd6);
      runSingle(0, OP_AND, 128'hFF00FF00_F0F0F0F0_12345678_AAAAAAAA,
                128'h0FF00FF0_FFFF0000_FFFFFFFF_55555555, 5'd6, 1'b0,
                128'h0F000F00_F0F00000_12345678_00000000, 1'b0, "and");
      runSingle(0, OP_OR, 128'hFF00FF00_F0F0F0F0_12345678_AAAAAAAA,
                128'h0FF00FF0_FFFF0000_FFFFFFFF_55555555, 5'd7, 1'b1,
                128'hFFF0FFF0_FFFFF0F0_FFFFFFFF_FFFFFFFF, 1'b1, "or");
      runSingle(0, OP_XOR, 128'hFF00FF00_F0F0F0F0_12345678_AAAAAAAA,
                128'h0FF00FF0_FFFF0000_FFFFFFFF_55555555, 5'd8, 1'b1,
                128'hF0F0F0F0_0F0FF0F0_EDCBA987_FFFFFFFF, 1'b1, "xor");
      runSingle(0, OP_RELU, 128'h80000000_7FFFFFFF_FFFFFFFF_00000001, {4{32'hFFFFFFFF}},
                5'd2, 1'b1, 128'h00000000_7FFFFFFF_00000000_00000001, 1'b1, "relu32");

      // MUL with a second op held on in_valid during the stall
      op = OP_MUL; src_a = 128'h00000005_00000004_00000003_00000002; src_b = {4{32'd3}};
      rd_in = 5'd9; regwrite_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("mul_busy",     128'(busy),     128'(1'b1));
      checkOutput("mul_in_ready", 128'(in_ready), 128'(1'b0));
      op = OP_ADD; src_a = 128'h00000001_00000002_00000003_00000004;
      src_b = 128'h0000000A_00000014_0000001E_00000028; rd_in = 5'd7;
      waitOutput(0, 12, lat);
      checkOutput("mul_lat",      128'(lat),          128'd4);
      checkOutput("mul_result",   alu_result_out,     128'h0000000F_0000000C_00000009_00000006);
      checkOutput("mul_rd",       128'(rd_out),       128'd9);
      checkOutput("mul_regwrite", 128'(regwrite_out), 128'(1'b1));
      checkOutput("mul_done_rdy", 128'(in_ready),     128'(1'b1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("b2b_valid",  128'(out_valid), 128'(1'b1));
      checkOutput("b2b_result", alu_result_out,  128'h0000000B_00000016_00000021_0000002C);
      checkOutput("b2b_rd",     128'(rd_out),    128'd7);

      // MUL keeps only the low lane bits; rd=0 never writes
      applyStimulus(0, OP_MUL, 128'hFFFFFFFF_00010000_0000FFFF_00000007,
                    128'hFFFFFFFF_00010001_0000FFFF_00000000, 5'd0, 1'b1);
      waitOutput(0, 12, lat);
      checkOutput("mulw_lat",      128'(lat),          128'd4);
      checkOutput("mulw_result",   alu_result_out,     128'h00000001_00010000_FFFE0001_00000000);
      checkOutput("mulw_regwrite", 128'(regwrite_out), 128'(1'b0));

      // DOT8
      applyStimulus(0, OP_DOT8, {16{8'h80}}, {16{8'h80}}, 5'd10, 1'b1);
      waitOutput(0, 12, lat);
      checkOutput("dot_lat",      128'(lat),          128'd4);
      checkOutput("dot_result",   alu_result_out,     128'h00040000);
      checkOutput("dot_regwrite", 128'(regwrite_out), 128'(1'b1));
      applyStimulus(0, OP_DOT8, {16{8'h7F}}, {16{8'h80}}, 5'd11, 1'b1);
      waitOutput(0, 12, lat);
      checkOutput("dot_neg_lat",    128'(lat),      128'd4);
      checkOutput("dot_neg_result", alu_result_out, 128'hFFFC0800);
      applyStimulus(0, OP_DOT8, 128'h100F0E0D0C0B0A090807060504030201, {8{16'hFF01}}, 5'd11, 1'b1);
      waitOutput(0, 12, lat);
      checkOutput("dot_mix_result", alu_result_out, 128'hFFFFFFF8);

      // 8-bit lanes
      runSingle(1, OP_RELU, {8{16'h807F}}, 128'h0, 5'd4, 1'b1, {8{16'h007F}}, 1'b1, "relu8");
      runSingle(1, OP_RELU, {8{16'h807F}}, 128'h0, 5'd0, 1'b1, {8{16'h007F}}, 1'b0, "relu8_rd0");
      runSingle(1, OP_ADD, {16{8'hFF}}, {16{8'h01}}, 5'd4, 1'b1, 128'h0, 1'b1, "add8");
      runSingle(1, OP_SUB, 128'h0, {16{8'h01}}, 5'd4, 1'b1, {16{8'hFF}}, 1'b1, "sub8");
      applyStimulus(1, OP_MUL, 128'h0F0E0D0C0B0A09080706050403020100, {16{8'h03}}, 5'd13, 1'b1);
      waitOutput(1, 40, lat);
      checkOutput("mul8_lat",    128'(lat),       128'd16);
      checkOutput("mul8_result", alu_result_out8, 128'h2D2A2724211E1B1815120F0C09060300);

      // Flush two cycles into a MUL
      applyStimulus(0, OP_MUL, {4{32'd2}}, {4{32'd2}}, 5'd3, 1'b1);
      @(posedge clk); #1;
      flush = 1'b1;
      #1;
      checkOutput("flush_in_ready", 128'(in_ready), 128'(1'b0));
      @(posedge clk); #1;
      checkOutput("flush_busy",  128'(busy),      128'(1'b0));
      checkOutput("flush_valid", 128'(out_valid), 128'(1'b0));
      flush = 1'b0;
      #1;
      checkOutput("flush_rdy_after", 128'(in_ready), 128'(1'b1));
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checkOutput("flush_no_pulse", 128'(seen), 128'd0);

      // Flush on the final BUSY edge suppresses the result
      applyStimulus(0, OP_MUL, {4{32'd2}}, {4{32'd2}}, 5'd3, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      checkOutput("flush_last_valid",    128'(out_valid),    128'(1'b0));
      checkOutput("flush_last_regwrite", 128'(regwrite_out), 128'(1'b0));
      checkOutput("flush_last_busy",     128'(busy),         128'(1'b0));
      // Flush while idle blocks an accept
      op = OP_ADD; src_a = {4{32'd1}}; src_b = {4{32'd1}}; rd_in = 5'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("flush_idle_valid", 128'(out_valid), 128'(1'b0));
      flush = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("flush_idle_after", 128'(out_valid), 128'(1'b0));

      // Illegal opcode
      runSingle(0, 4'hA, {4{32'h12345678}}, {4{32'h1}}, 5'd3, 1'b1, 128'h0, 1'b0, "illegal");
      checkOutput("illegal_flag", 128'(illegal_op), 128'(1'b1));
      @(posedge clk); #1;
      checkOutput("illegal_pulse", 128'(illegal_op), 128'(1'b0));

      // Reset during DOT8 BUSY
      runSingle(0, OP_ADD, {4{32'h11111111}}, {4{32'h22222222}}, 5'd12, 1'b1,
                {4{32'h33333333}}, 1'b1, "pre_rst");
      applyStimulus(0, OP_DOT8, {16{8'h01}}, {16{8'h01}}, 5'd12, 1'b1);
      reset = 1'b1;
      #1;
      checkOutput("arst_result",   alu_result_out,     128'h0);
      checkOutput("arst_rd",       128'(rd_out),       128'h0);
      checkOutput("arst_busy",     128'(busy),         128'(1'b0));
      checkOutput("arst_regwrite", 128'(regwrite_out), 128'(1'b0));
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checkOutput("arst_no_pulse", 128'(seen), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
